// File: rtl/panda_risc_v_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider between REQ_N requesters.
// An in-order tag FIFO routes results back; `DIV_ARB_PERF_CNT_EN adds perf counters.
module panda_risc_v_div_arbiter #(
    parameter int REQ_N            = 2,
    parameter int ORDER_FIFO_DEPTH = 4,
    parameter int simulation_delay = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQ_N*33-1:0]                 s_req_op_a,
    input  logic [REQ_N*33-1:0]                 s_req_op_b,
    input  logic [REQ_N-1:0]                    s_req_rem_sel,
    input  logic [REQ_N-1:0]                    s_req_valid,
    output logic [REQ_N-1:0]                    s_req_ready,
    output logic [REQ_N*32-1:0]                 s_res_data,
    output logic [REQ_N-1:0]                    s_res_valid,
    input  logic [REQ_N-1:0]                    s_res_ready,
    output logic [32:0]                         m_div_req_op_a,
    output logic [32:0]                         m_div_req_op_b,
    output logic                                m_div_req_rem_sel,
    output logic                                m_div_req_valid,
    input  logic                                m_div_req_ready,
    input  logic [31:0]                         m_div_res_data,
    input  logic                                m_div_res_valid,
    output logic                                m_div_res_ready,
    output logic [$clog2(ORDER_FIFO_DEPTH):0]   div_outstanding
`ifdef DIV_ARB_PERF_CNT_EN
    ,
    output logic [REQ_N*32-1:0]                 perf_req_cnt,
    output logic [31:0]                         perf_stall_cnt
`endif
);

    localparam int IW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int AW = $clog2(ORDER_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(ORDER_FIFO_DEPTH);
    localparam logic [IW:0]   REQ_N_C = (IW + 1)'(REQ_N);

    // Synthesised logic applies no delays; the simulation delay only exists
    // so existing instantiations keep the same parameter list.
    if (simulation_delay < 0) begin : g_neg_sim_delay
    end

    logic [IW-1:0] rr_q, rr_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic [IW-1:0] tags_q [ORDER_FIFO_DEPTH];
    logic [IW-1:0] tags_d [ORDER_FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] rr_pick;
    logic [IW-1:0] grant;
    logic [IW-1:0] head;
    logic          any_valid;
    logic          tag_full;
    logic          tag_empty;
    logic          req_hs;
    logic          res_hs;

    assign any_valid = |s_req_valid;
    assign tag_full  = (cnt_q == DEPTH_C);
    assign tag_empty = (cnt_q == '0);
    assign head      = tags_q[rptr_q];
    assign grant     = lock_q ? lock_idx_q : rr_pick;

    // Round-robin search: first valid requester at or after the rr pointer.
    always_comb begin
        logic [IW:0] sum;
        logic        found;
        rr_pick = rr_q;
        found   = 1'b0;
        for (int k = 0; k < REQ_N; k++) begin
            sum = {1'b0, rr_q} + (IW + 1)'(k);
            if (sum >= REQ_N_C) begin
                sum = sum - REQ_N_C;
            end
            if (!found && s_req_valid[sum[IW-1:0]]) begin
                found   = 1'b1;
                rr_pick = sum[IW-1:0];
            end
        end
    end

    // Request channel: payload mux from the granted requester and ready fan-out.
    always_comb begin
        m_div_req_op_a    = '0;
        m_div_req_op_b    = '0;
        m_div_req_rem_sel = 1'b0;
        s_req_ready       = '0;
        m_div_req_valid   = any_valid & ~tag_full;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant == IW'(i)) begin
                m_div_req_op_a    = s_req_op_a[i*33 +: 33];
                m_div_req_op_b    = s_req_op_b[i*33 +: 33];
                m_div_req_rem_sel = s_req_rem_sel[i];
                s_req_ready[i]    = any_valid & m_div_req_ready & ~tag_full;
            end
        end
    end

    assign req_hs = m_div_req_valid & m_div_req_ready;

    // Result channel: only the head-of-queue owner sees valid and drives ready.
    always_comb begin
        s_res_valid     = '0;
        m_div_res_ready = s_res_ready[head] & ~tag_empty;
        for (int i = 0; i < REQ_N; i++) begin
            s_res_valid[i] = (head == IW'(i)) & m_div_res_valid & ~tag_empty;
        end
    end

    assign res_hs          = m_div_res_valid & m_div_res_ready;
    assign s_res_data      = {REQ_N{m_div_res_data}};
    assign div_outstanding = cnt_q;

    // Next state: grant lock, rr pointer advance and tag FIFO push/pop.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        tags_d     = tags_q;
        if (req_hs) begin
            tags_d[wptr_q] = grant;
            wptr_d         = wptr_q + 1'b1;
            rr_d           = (grant == IW'(REQ_N - 1)) ? '0 : grant + 1'b1;
            lock_d         = 1'b0;
        end else if (m_div_req_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (res_hs) begin
            rptr_d = rptr_q + 1'b1;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, req_hs} - {{AW{1'b0}}, res_hs};
    end

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
        tags_q <= tags_d;
    end

`ifdef DIV_ARB_PERF_CNT_EN
    logic [REQ_N*32-1:0] perf_req_cnt_q, perf_req_cnt_d;
    logic [31:0]         perf_stall_cnt_q, perf_stall_cnt_d;

    // Per-requester accepted-request counts and divider stall cycles.
    always_comb begin
        perf_req_cnt_d   = perf_req_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        for (int i = 0; i < REQ_N; i++) begin
            if (req_hs && grant == IW'(i)) begin
                perf_req_cnt_d[i*32 +: 32] = perf_req_cnt_q[i*32 +: 32] + 32'd1;
            end
        end
        if (m_div_req_valid && !m_div_req_ready) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_cnt_q   <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_req_cnt_q   <= perf_req_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_req_cnt   = perf_req_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_panda_risc_v_div_arbiter.sv
// Bench for panda_risc_v_div_arbiter: requester agents, divider model, result scoreboard.
// Define DIV_ARB_PERF_CNT_EN to also check the perf counters.
module tb_panda_risc_v_div_arbiter;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rem;
    } op_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [65:0] s_req_op_a = '0;
    logic [65:0] s_req_op_b = '0;
    logic [1:0]  s_req_rem_sel = '0;
    logic [1:0]  s_req_valid = '0;
    logic [1:0]  s_req_ready;
    logic [63:0] s_res_data;
    logic [1:0]  s_res_valid;
    logic [1:0]  s_res_ready = 2'b11;
    logic [32:0] m_div_req_op_a;
    logic [32:0] m_div_req_op_b;
    logic        m_div_req_rem_sel;
    logic        m_div_req_valid;
    logic        m_div_req_ready = 1'b1;
    logic [31:0] m_div_res_data = '0;
    logic        m_div_res_valid = 1'b0;
    logic        m_div_res_ready;
    logic [2:0]  div_outstanding;
`ifdef DIV_ARB_PERF_CNT_EN
    logic [63:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic res_en = 1'b1;
    logic stray  = 1'b0;

    op_t         agq0[$];
    op_t         agq1[$];
    logic [31:0] div_q[$];
    exp_t        exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    panda_risc_v_div_arbiter #(
        .REQ_N(2),
        .ORDER_FIFO_DEPTH(4),
        .simulation_delay(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_req_op_a(s_req_op_a),
        .s_req_op_b(s_req_op_b),
        .s_req_rem_sel(s_req_rem_sel),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .s_res_data(s_res_data),
        .s_res_valid(s_res_valid),
        .s_res_ready(s_res_ready),
        .m_div_req_op_a(m_div_req_op_a),
        .m_div_req_op_b(m_div_req_op_b),
        .m_div_req_rem_sel(m_div_req_rem_sel),
        .m_div_req_valid(m_div_req_valid),
        .m_div_req_ready(m_div_req_ready),
        .m_div_res_data(m_div_res_data),
        .m_div_res_valid(m_div_res_valid),
        .m_div_res_ready(m_div_res_ready),
        .div_outstanding(div_outstanding)
`ifdef DIV_ARB_PERF_CNT_EN
        ,
        .perf_req_cnt(perf_req_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] div_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic rem);
        return rem ? (a % b) : (a / b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input int r, input logic [31:0] a,
                           input logic [31:0] b, input logic rem);
        op_t  o;
        exp_t e;
        o.a = a;
        o.b = b;
        o.rem = rem;
        e.owner = r;
        e.data = div_fn(a, b, rem);
        if (r == 0) agq0.push_back(o);
        else        agq1.push_back(o);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((agq0.size() + agq1.size() + exp_q.size()) != 0 && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", agq0.size() + agq1.size() + exp_q.size(), 0);
    endtask

    task automatic wait_outst(input int n, input int budget);
        int k = 0;
        while (int'(div_outstanding) != n && k < budget) begin
            step();
            k++;
        end
        chk("outst_wait", div_outstanding, n);
    endtask

    // Requester agents and divider model drive inputs 2 time units after posedge.
    always @(posedge clk) begin
        #2;
        s_req_valid[0] = agq0.size() > 0;
        if (agq0.size() > 0) begin
            s_req_op_a[32:0] = {1'b0, agq0[0].a};
            s_req_op_b[32:0] = {1'b0, agq0[0].b};
            s_req_rem_sel[0] = agq0[0].rem;
        end
        s_req_valid[1] = agq1.size() > 0;
        if (agq1.size() > 0) begin
            s_req_op_a[65:33] = {1'b0, agq1[0].a};
            s_req_op_b[65:33] = {1'b0, agq1[0].b};
            s_req_rem_sel[1] = agq1[0].rem;
        end
        m_div_res_valid = stray || (res_en && div_q.size() > 0);
        m_div_res_data = (div_q.size() > 0) ? div_q[0] : 32'hdead_beef;
    end

    // Monitor at negedge: observe handshakes, advance models, score results.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (m_div_res_valid && div_outstanding == 3'd0) begin
                chk("res_ready_when_empty", m_div_res_ready, 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (s_res_valid[i] && s_res_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_owner", i, e.owner);
                        chk("res_data", s_res_data[i*32 +: 32], e.data);
                    end
                end
            end
            if (m_div_res_valid && m_div_res_ready && div_q.size() > 0) begin
                void'(div_q.pop_front());
            end
            if (m_div_req_valid && m_div_req_ready) begin
                chk("req_ready_onehot", $countones(s_req_ready), 1);
                div_q.push_back(div_fn(m_div_req_op_a[31:0],
                                       m_div_req_op_b[31:0],
                                       m_div_req_rem_sel));
                if (s_req_valid[0] && s_req_ready[0]) void'(agq0.pop_front());
                if (s_req_valid[1] && s_req_ready[1]) void'(agq1.pop_front());
            end
        end
    end

    initial begin
        repeat (2) step();
        rst = 1'b0;
        #3;
        chk("rst_outst", div_outstanding, 0);
        chk("rst_req_valid", m_div_req_valid, 0);
        chk("rst_req_ready", s_req_ready, 0);
        chk("rst_res_valid", s_res_valid, 0);
        chk("rst_res_ready", m_div_res_ready, 0);

        // Simultaneous requests: req0 then req1.
        step();
        push_op(0, 32'd1000, 32'd10, 1'b0);
        push_op(1, 32'd1001, 32'd10, 1'b1);
        #3;
        chk("t1_req_valid", m_div_req_valid, 1);
        chk("t1_grant0", s_req_ready, 2'b01);
        step();
        #3;
        chk("t1_grant1", s_req_ready, 2'b10);
        wait_idle(50);

        // Move rr to requester 1, then check grant lock holds req0.
        step();
        push_op(0, 32'd21, 32'd4, 1'b1);
        wait_idle(50);
        m_div_req_ready = 1'b0;
        push_op(0, 32'd100, 32'd7, 1'b0);
        #3;
        chk("t2_valid", m_div_req_valid, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) push_op(1, 32'd53, 32'd5, 1'b1);
            #3;
            chk("t2_op_a", m_div_req_op_a, 33'd100);
            chk("t2_op_b", m_div_req_op_b, 33'd7);
            chk("t2_rem", m_div_req_rem_sel, 0);
            chk("t2_no_ready", s_req_ready, 2'b00);
        end
        step();
        m_div_req_ready = 1'b1;
        #3;
        chk("t2_grant0", s_req_ready, 2'b01);
        wait_idle(50);

        // Fill the tag FIFO with results held back.
        step();
        res_en = 1'b0;
        push_op(0, 32'd40, 32'd3, 1'b0);
        push_op(1, 32'd41, 32'd3, 1'b1);
        push_op(0, 32'd42, 32'd5, 1'b0);
        push_op(1, 32'd43, 32'd5, 1'b1);
        wait_outst(4, 20);
        push_op(0, 32'd77, 32'd7, 1'b0);
        #3;
        chk("t3_full_valid", m_div_req_valid, 0);
        chk("t3_full_ready", s_req_ready, 2'b00);
        step();
        #3;
        chk("t3_full_valid2", m_div_req_valid, 0);
        chk("t3_outst4", div_outstanding, 4);
        step();
        res_en = 1'b1;
        #3;
        chk("t3_pop_ready", m_div_res_ready, 1);
        step();
        res_en = 1'b0;
        #3;
        chk("t3_outst3", div_outstanding, 3);
        chk("t3_reissue", m_div_req_valid, 1);
        chk("t3_reissue_rdy", s_req_ready, 2'b01);
        step();
        #3;
        chk("t3_outst4b", div_outstanding, 4);
        res_en = 1'b1;
        wait_idle(50);

        // Owner backpressure on requester 1 stalls the divider.
        step();
        s_res_ready = 2'b01;
        push_op(1, 32'd90, 32'd9, 1'b0);
        begin
            int k = 0;
            step();
            #3;
            while (!m_div_res_valid && k < 20) begin
                step();
                #3;
                k++;
            end
        end
        chk("t4_res_valid", m_div_res_valid, 1);
        for (int k = 0; k < 3; k++) begin
            chk("t4_stall", m_div_res_ready, 0);
            chk("t4_route", s_res_valid, 2'b10);
            step();
            #3;
        end
        step();
        s_res_ready = 2'b11;
        #3;
        chk("t4_release", m_div_res_ready, 1);
        wait_idle(50);

        // Stray divider result with nothing in flight.
        step();
        stray = 1'b1;
        #3;
        chk("stray_ready", m_div_res_ready, 0);
        chk("stray_route", s_res_valid, 2'b00);
        step();
        stray = 1'b0;

        // Reset with three ops in flight; rr returns to requester 0.
        res_en = 1'b0;
        push_op(0, 32'd60, 32'd6, 1'b0);
        push_op(1, 32'd61, 32'd6, 1'b1);
        push_op(0, 32'd62, 32'd6, 1'b0);
        wait_outst(3, 20);
        step();
        rst = 1'b1;
        agq0.delete();
        agq1.delete();
        div_q.delete();
        exp_q.delete();
        step();
        rst = 1'b0;
        #3;
        chk("t5_outst", div_outstanding, 0);
        chk("t5_res_valid", s_res_valid, 2'b00);
        chk("t5_req_valid", m_div_req_valid, 0);
        chk("t5_res_ready", m_div_res_ready, 0);
        step();
        res_en = 1'b1;
        push_op(0, 32'd11, 32'd2, 1'b0);
        push_op(1, 32'd13, 32'd2, 1'b1);
        #3;
        chk("t5_rr_reset", s_req_ready, 2'b01);
        wait_idle(50);

`ifdef DIV_ARB_PERF_CNT_EN
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_div_req_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push_op(0, 32'(k * 3 + 5), 32'd3, 1'b0);
            push_op(1, 32'(k * 3 + 6), 32'd3, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            push_op(0, 32'(k + 30), 32'd4, 1'b0);
        end
        repeat (4) step();
        m_div_req_ready = 1'b1;
        wait_idle(300);
        chk("perf_req_cnt", perf_req_cnt, {32'd6, 32'd10});
        chk("perf_stall_cnt", perf_stall_cnt, 32'd4);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
